// File: rtl/bus_arb_pkg.sv
// Shared types and default parameters for the bus arbiter slice.
package bus_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_RD_LATENCY = 1;

  // Arbiter FSM: wait for a winner, issue one bus command, wait out read latency.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one slot after the
// last granted requester and wraps, so the previous winner is checked last.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // First asserted request found walking forward from last_grant+1.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-requester bus arbiter. One transaction is in flight at a time:
// a round-robin winner is accepted in IDLE, its command is presented on the
// bus for exactly one cycle, reads then wait RD_LATENCY cycles for data, and
// the winner receives a one-cycle rsp_valid pulse.
//
// Handshake: a requester's transaction is accepted on the rising edge where
// req_valid[i] & req_ready[i] are both high. req_ready is combinational, only
// ever high in IDLE (and out of reset), and at most one bit is set. Fields
// must be held stable while valid and not ready; dropping valid before
// accept withdraws the request, dropping it after accept changes nothing.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wr_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rd_data,
  output logic                           bus_cmd_valid,
  output logic                           bus_op,
  output logic [ADDR_WIDTH-1:0]          bus_addr,
  output logic [DATA_WIDTH-1:0]          bus_wr_data,
  input  logic [DATA_WIDTH-1:0]          bus_rd_data,
  output logic                           busy,
  output arb_state_e                     dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  arb_state_e            state_q,       state_d;
  logic [IDX_W-1:0]      last_grant_q,  last_grant_d;
  logic [IDX_W-1:0]      gnt_idx_q,     gnt_idx_d;
  logic                  cmd_valid_q,   cmd_valid_d;
  logic                  op_q,          op_d;
  logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,     wr_data_d;
  logic [NUM_REQ-1:0]    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Offer the round-robin winner only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE)) begin
      req_ready = arb_grant;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_idx_d     = gnt_idx_q;
    cmd_valid_d   = 1'b0;
    op_d          = op_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    rsp_valid_d   = '0;
    rsp_rd_data_d = rsp_rd_data_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = CMD;
          last_grant_d = arb_idx;
          gnt_idx_d    = arb_idx;
          cmd_valid_d  = 1'b1;
          op_d         = req_op[arb_idx];
          addr_d       = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wr_data_d    = req_wr_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      CMD: begin
        if (op_q) begin
          // Writes complete as soon as the command has been on the bus.
          state_d                = IDLE;
          rsp_valid_d[gnt_idx_q] = 1'b1;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = CNT_W'(RD_LATENCY);
        end
      end
      RD_WAIT: begin
        // The last wait cycle is the one in which bus_rd_data is valid.
        if (cnt_q == CNT_W'(1)) begin
          state_d                = IDLE;
          cnt_d                  = '0;
          rsp_rd_data_d          = bus_rd_data;
          rsp_valid_d[gnt_idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All FSM state and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      gnt_idx_q     <= '0;
      cmd_valid_q   <= 1'b0;
      op_q          <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_rd_data_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_idx_q     <= gnt_idx_d;
      cmd_valid_q   <= cmd_valid_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus_cmd_valid = cmd_valid_q;
  assign bus_op        = op_q;
  assign bus_addr      = addr_q;
  assign bus_wr_data   = wr_data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rd_data   = rsp_rd_data_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3, sharing a clock. Inputs change at the falling edge,
// outputs are sampled 1ns later.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with RD_LATENCY = 1
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_op, rsp_valid;
  logic [31:0] req_addr, req_wr_data;
  logic [15:0] rsp_rd_data, bus_addr, bus_wr_data, bus_rd_data;
  logic        bus_cmd_valid, bus_op, busy;
  arb_state_e  dbg_state;

  // Instance with RD_LATENCY = 3
  logic        l3_rst_n;
  logic [1:0]  l3_req_valid, l3_req_ready, l3_req_op, l3_rsp_valid;
  logic [31:0] l3_req_addr, l3_req_wr_data;
  logic [15:0] l3_rsp_rd_data, l3_bus_addr, l3_bus_wr_data, l3_bus_rd_data;
  logic        l3_bus_cmd_valid, l3_bus_op, l3_busy;
  arb_state_e  l3_dbg_state;

  bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_REQ(2), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .bus_cmd_valid(bus_cmd_valid),
    .bus_op(bus_op), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .busy(busy), .dbg_state(dbg_state)
  );

  bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_REQ(2), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(l3_rst_n), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_op(l3_req_op), .req_addr(l3_req_addr), .req_wr_data(l3_req_wr_data),
    .rsp_valid(l3_rsp_valid), .rsp_rd_data(l3_rsp_rd_data), .bus_cmd_valid(l3_bus_cmd_valid),
    .bus_op(l3_bus_op), .bus_addr(l3_bus_addr), .bus_wr_data(l3_bus_wr_data),
    .bus_rd_data(l3_bus_rd_data), .busy(l3_busy), .dbg_state(l3_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Read on the latency-3 instance; c counts cycles after the accept cycle.
  task automatic l3_read(input logic r, input logic [15:0] addr,
                         input logic [15:0] data, input string tag);
    int busy_n = 0;
    int wait_n = 0;
    int rsp_n  = 0;
    int rsp_at = -1;
    @(negedge clk);
    l3_req_valid   = r ? 2'b10 : 2'b01;
    l3_req_op      = 2'b00;
    l3_req_addr    = {addr, addr};
    l3_bus_rd_data = 16'hDEAD;
    #1;
    check({tag, "_ready"}, l3_req_ready, r ? 2'b10 : 2'b01);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      l3_req_valid   = 2'b00;
      l3_bus_rd_data = (c == 4) ? data : (16'hDE00 | 16'(c));
      #1;
      if (c == 1) begin
        check({tag, "_cmd_valid"}, l3_bus_cmd_valid, 1);
        check({tag, "_cmd_op"},    l3_bus_op, 0);
        check({tag, "_cmd_addr"},  l3_bus_addr, addr);
      end
      if (l3_busy) busy_n++;
      if (l3_dbg_state == RD_WAIT) wait_n++;
      if (l3_rsp_valid != 2'b00) begin
        rsp_n++;
        if (rsp_at < 0) begin
          rsp_at = c;
          check({tag, "_rsp_who"},  l3_rsp_valid, r ? 2'b10 : 2'b01);
          check({tag, "_rsp_data"}, l3_rsp_rd_data, data);
        end
      end
    end
    check({tag, "_busy_cycles"}, busy_n, 4);
    check({tag, "_wait_cycles"}, wait_n, 3);
    check({tag, "_rsp_cycle"},   rsp_at, 5);
    check({tag, "_rsp_pulses"},  rsp_n, 1);
    check({tag, "_rd_hold"},     l3_rsp_rd_data, data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt[2];
    int cyc_i, last_acc, prev_g, g;
    logic [15:0] acc_addr;

    rst_n = 1'b0;       l3_rst_n = 1'b0;
    req_valid = 2'b01;  l3_req_valid = 2'b01;
    req_op = 2'b00;     l3_req_op = 2'b00;
    req_addr = '0;      l3_req_addr = '0;
    req_wr_data = '0;   l3_req_wr_data = '0;
    bus_rd_data = '0;   l3_bus_rd_data = '0;

    // Reset: ready held low even with a request pending.
    @(negedge clk); #1;
    check("rst_ready",    req_ready, 2'b00);
    check("rst3_ready",   l3_req_ready, 2'b00);
    @(negedge clk); #1;
    check("rst_ready2",   req_ready, 2'b00);
    check("rst_cmd",      bus_cmd_valid, 0);
    check("rst_addr",     bus_addr, 0);
    check("rst_wdata",    bus_wr_data, 0);
    check("rst_rsp",      rsp_valid, 0);
    check("rst_rdata",    rsp_rd_data, 0);
    check("rst_busy",     busy, 0);
    check("rst_state",    dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1; l3_rst_n = 1'b1;
    req_valid = 2'b00; l3_req_valid = 2'b00;

    // Write from requester 0.
    @(negedge clk);
    req_valid = 2'b01; req_op = 2'b01;
    req_addr[15:0] = 16'h0010; req_wr_data[15:0] = 16'hA5A5;
    #1; check("wr_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00; #1;
    check("wr_cmd_valid", bus_cmd_valid, 1);
    check("wr_cmd_op",    bus_op, 1);
    check("wr_cmd_addr",  bus_addr, 16'h0010);
    check("wr_cmd_data",  bus_wr_data, 16'hA5A5);
    check("wr_busy",      busy, 1);
    check("wr_state",     dbg_state, CMD);
    check("wr_rsp_early", rsp_valid, 2'b00);
    @(negedge clk); #1;
    check("wr_cmd_drop",  bus_cmd_valid, 0);
    check("wr_addr_hold", bus_addr, 16'h0010);
    check("wr_rsp",       rsp_valid, 2'b01);
    check("wr_idle",      busy, 0);
    @(negedge clk); #1;
    check("wr_rsp_pulse", rsp_valid, 2'b00);

    // Read from requester 1, data returned one cycle after the command.
    @(negedge clk);
    req_valid = 2'b10; req_op = 2'b00; req_addr[31:16] = 16'h0020;
    bus_rd_data = 16'hDEAD;
    #1; check("rd_ready", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b00; #1;
    check("rd_cmd_valid", bus_cmd_valid, 1);
    check("rd_cmd_op",    bus_op, 0);
    check("rd_cmd_addr",  bus_addr, 16'h0020);
    @(negedge clk); bus_rd_data = 16'h1234; #1;
    check("rd_state",     dbg_state, RD_WAIT);
    check("rd_rsp_early", rsp_valid, 2'b00);
    @(negedge clk); bus_rd_data = 16'hBEEF; #1;
    check("rd_rsp",       rsp_valid, 2'b10);
    check("rd_data",      rsp_rd_data, 16'h1234);
    check("rd_idle",      busy, 0);
    @(negedge clk); #1;
    check("rd_rsp_pulse", rsp_valid, 2'b00);
    check("rd_data_hold", rsp_rd_data, 16'h1234);

    // Both requesters writing continuously: grants alternate starting at 0,
    // one accept every 2 cycles, each accept coinciding with the previous rsp.
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
    end
    cnt[0] = 0; cnt[1] = 0;
    cyc_i = 0; last_acc = -10; prev_g = -1; acc_addr = '0;
    req_op = 2'b11;
    while (exp_q.size() != 0 && cyc_i < 60) begin
      @(negedge clk);
      req_valid   = 2'b11;
      req_addr    = {16'(32'h0200 + cnt[1]), 16'(32'h0100 + cnt[0])};
      req_wr_data = {16'(32'hC100 + cnt[1]), 16'(32'hC000 + cnt[0])};
      #1;
      if (cyc_i == last_acc + 1) begin
        check("rr_cmd_valid", bus_cmd_valid, 1);
        check("rr_cmd_addr",  bus_addr, acc_addr);
      end
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        check("rr_onehot", req_ready, 2'b01 << g);
        check("rr_grant",  g, exp_q.pop_front());
        if (prev_g >= 0) begin
          check("rr_gap", cyc_i - last_acc, 2);
          check("rr_rsp", rsp_valid, 2'b01 << prev_g);
        end
        acc_addr = g ? req_addr[31:16] : req_addr[15:0];
        cnt[g]++;
        prev_g = g;
        last_acc = cyc_i;
      end
      cyc_i++;
    end
    check("rr_all_granted", exp_q.size(), 0);
    @(negedge clk); req_valid = 2'b00; #1;
    check("rr_last_cmd",  bus_addr, 16'h0205);
    @(negedge clk); #1;
    check("rr_last_rsp",  rsp_valid, 2'b10);
    check("rr_cnt0",      cnt[0], 6);
    check("rr_cnt1",      cnt[1], 6);

    // Latency-3 read.
    l3_read(1'b0, 16'h0030, 16'h3C3C, "l3_rd");

    // Reset during RD_WAIT abandons the read.
    @(negedge clk);
    l3_req_valid = 2'b01; l3_req_op = 2'b00; l3_req_addr = {16'h0040, 16'h0040};
    #1; check("ab_ready", l3_req_ready, 2'b01);
    @(negedge clk); l3_req_valid = 2'b00; #1;
    check("ab_cmd", l3_bus_cmd_valid, 1);
    @(negedge clk); #1;
    check("ab_wait", l3_dbg_state, RD_WAIT);
    @(negedge clk); l3_rst_n = 1'b0; l3_req_valid = 2'b01; #1;
    check("ab_ready_in_rst", l3_req_ready, 2'b00);
    @(negedge clk); l3_rst_n = 1'b1; l3_req_valid = 2'b00; l3_bus_rd_data = 16'h3333; #1;
    check("ab_state", l3_dbg_state, IDLE);
    check("ab_busy",  l3_busy, 0);
    check("ab_cmd0",  l3_bus_cmd_valid, 0);
    check("ab_op0",   l3_bus_op, 0);
    check("ab_addr0", l3_bus_addr, 0);
    check("ab_rdata", l3_rsp_rd_data, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("ab_no_rsp", l3_rsp_valid, 2'b00);
      check("ab_no_cmd", l3_bus_cmd_valid, 0);
    end

    // After reset requester 0 is first in line; a withdrawn request is ignored.
    @(negedge clk); l3_req_valid = 2'b11; #1;
    check("ab_rr_restart", l3_req_ready, 2'b01);
    #1; l3_req_valid = 2'b00;
    @(negedge clk); #1;
    check("ab_withdraw_idle", l3_busy, 0);

    l3_read(1'b1, 16'h0050, 16'h7777, "l3_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
